multicycle_control_fsm: RTL and testbench

Control unit for the multicycle RV32I core that shares one ALU and one unified instruction/data memory across several cycles per instruction. It sequences fetch, decode, execute, memory and writeback by driving every datapath mux select and write enable from a registered state, and stalls on a memory ready handshake. It covers the instructions the single-cycle core supports: lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/riscv_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_control_fsm_alu_decoder.sv | 31 +++
 rtl/multicycle_control_fsm.sv | 149 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// ALU control codes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // alu_op is the FSM's request to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's alu_op request plus the
// instruction funct fields into the 3-bit alu_control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type uses funct7b5 to select sub; I-type addi ignores it
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: registered state sequencing fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic [1:0] result_src_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] imm_src_o,
    output logic       reg_write_o,
    output logic [2:0] alu_control_o,
    output logic       instr_done_o,
    output logic       illegal_op_o,
    output logic [3:0] state_o
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_write, mem_write, ir_write, reg_write, instr_done, illegal_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b0;
        adr_src_o    = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RD2;
        imm_src_o    = IMM_I;
        reg_write    = 1'b0;
        alu_op       = ALUOP_ADD;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALURESULT;
                ir_write     = mem_ready_i;
                pc_write     = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                imm_src_o   = IMM_B;
                case (op_i)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_IMM;
                imm_src_o   = op_i[5] ? IMM_S : IMM_I;
                state_d     = op_i[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_o = RES_DATA;
                reg_write    = 1'b1;
                instr_done   = 1'b1;
                state_d      = S_FETCH;
            end
            // The strobe is held through the stall; memory commits on the ready cycle
            S_MEMWRITE: begin
                adr_src_o  = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a_o = SRCA_RD1;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a_o = SRCA_RD1;
                alu_src_b_o = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_write    = 1'b1;
                state_d     = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a_o = SRCA_RD1;
                alu_op      = ALUOP_SUB;
                pc_write    = zero_i;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3_i),
        .funct7b5_i    (funct7b5_i),
        .op5_i         (op_i[5]),
        .alu_control_o (alu_control_o)
    );

    // Reset masks every enable and pulse so nothing commits while the core is held
    assign pc_write_o   = pc_write   & ~rst;
    assign mem_write_o  = mem_write  & ~rst;
    assign ir_write_o   = ir_write   & ~rst;
    assign reg_write_o  = reg_write  & ~rst;
    assign instr_done_o = instr_done & ~rst;
    assign illegal_op_o = illegal_op & ~rst;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed self-checking bench for multicycle_control_fsm: per-cycle state and
// control checks for each instruction class, stalls, illegal opcode and reset.
module tb_multicycle_control_fsm;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_ADDI = 32'h40008093;
    localparam logic [31:0] I_LW   = 32'h0040A183;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    logic        clk, rst;
    logic [31:0] instr;
    logic        zero, memReady;
    logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, done, illegal;
    logic [1:0]  resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0]  aluControl;
    logic [3:0]  state;
    int          vectorCount = 0;
    int          missCount   = 0;

    multicycle_control_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .op_i          (instr[6:0]),
        .funct3_i      (instr[14:12]),
        .funct7b5_i    (instr[30]),
        .zero_i        (zero),
        .mem_ready_i   (memReady),
        .pc_write_o    (pcWrite),
        .adr_src_o     (adrSrc),
        .mem_write_o   (memWrite),
        .ir_write_o    (irWrite),
        .result_src_o  (resultSrc),
        .alu_src_a_o   (aluSrcA),
        .alu_src_b_o   (aluSrcB),
        .imm_src_o     (immSrc),
        .reg_write_o   (regWrite),
        .alu_control_o (aluControl),
        .instr_done_o  (done),
        .illegal_op_o  (illegal),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change right after the falling edge; outputs are sampled 1ns later
    task automatic applyStimulus(input logic [31:0] instrIn, input logic zeroIn, input logic readyIn);
        instr    = instrIn;
        zero     = zeroIn;
        memReady = readyIn;
        #1;
    endtask

    task automatic advance(input logic [31:0] instrIn, input logic zeroIn, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(instrIn, zeroIn, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic measureCycles(input string tag, input logic [31:0] instrIn, input logic zeroIn, input int expCycles);
        int   cycles;
        logic seen;
        cycles = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus(instrIn, zeroIn, 1'b1);
            cycles++;
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        checkOutput(tag, cycles, expCycles);
        applyStimulus(instrIn, zeroIn, 1'b0);
        checkOutput({tag, "_end"}, state, 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; zero = 1'b0; memReady = 1'b1;
        #7;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_irw", irWrite, 0);
        checkOutput("rst_pcw", pcWrite, 0);
        checkOutput("rst_srcb", aluSrcB, 2);
        checkOutput("rst_res", resultSrc, 2);
        @(negedge clk);
        rst = 1'b0;

        // add: 0,1,6,7,0
        applyStimulus(I_ADD, 0, 1);
        checkOutput("add_f_state", state, 0);
        checkOutput("add_f_irw", irWrite, 1);
        checkOutput("add_f_pcw", pcWrite, 1);
        checkOutput("add_f_regw", regWrite, 0);
        @(negedge clk);
        applyStimulus(I_ADD, 0, 1);
        checkOutput("add_d_state", state, 1);
        checkOutput("add_d_srca", aluSrcA, 1);
        checkOutput("add_d_srcb", aluSrcB, 1);
        checkOutput("add_d_imm", immSrc, 2);
        checkOutput("add_d_done", done, 0);
        @(negedge clk);
        applyStimulus(I_ADD, 0, 1);
        checkOutput("add_x_state", state, 6);
        checkOutput("add_x_alu", aluControl, 0);
        checkOutput("add_x_srca", aluSrcA, 2);
        checkOutput("add_x_srcb", aluSrcB, 0);
        checkOutput("add_x_regw", regWrite, 0);
        @(negedge clk);
        applyStimulus(I_ADD, 0, 1);
        checkOutput("add_wb_state", state, 7);
        checkOutput("add_wb_regw", regWrite, 1);
        checkOutput("add_wb_res", resultSrc, 0);
        checkOutput("add_wb_done", done, 1);
        @(negedge clk);

        // funct decode variants observed in the execute state
        advance(I_SUB, 0, 2);
        applyStimulus(I_SUB, 0, 1);
        checkOutput("sub_x_alu", aluControl, 1);
        advance(I_SUB, 0, 2);
        advance(I_SLT, 0, 2);
        applyStimulus(I_SLT, 0, 1);
        checkOutput("slt_x_alu", aluControl, 5);
        advance(I_SLT, 0, 2);
        advance(I_OR, 0, 2);
        applyStimulus(I_OR, 0, 1);
        checkOutput("or_x_alu", aluControl, 3);
        advance(I_OR, 0, 2);
        advance(I_AND, 0, 2);
        applyStimulus(I_AND, 0, 1);
        checkOutput("and_x_alu", aluControl, 2);
        advance(I_AND, 0, 2);
        advance(I_ADDI, 0, 2);
        applyStimulus(I_ADDI, 0, 1);
        checkOutput("addi_x_state", state, 8);
        checkOutput("addi_x_alu", aluControl, 0);
        checkOutput("addi_x_srcb", aluSrcB, 1);
        advance(I_ADDI, 0, 2);

        // lw with two stall cycles in MEMREAD
        advance(I_LW, 0, 2);
        applyStimulus(I_LW, 0, 1);
        checkOutput("lw_ma_state", state, 2);
        checkOutput("lw_ma_imm", immSrc, 0);
        @(negedge clk);
        applyStimulus(I_LW, 0, 0);
        checkOutput("lw_mr_state0", state, 3);
        checkOutput("lw_mr_adr", adrSrc, 1);
        @(negedge clk);
        applyStimulus(I_LW, 0, 0);
        checkOutput("lw_mr_state1", state, 3);
        @(negedge clk);
        applyStimulus(I_LW, 0, 1);
        checkOutput("lw_mr_state2", state, 3);
        checkOutput("lw_mr_regw", regWrite, 0);
        @(negedge clk);
        applyStimulus(I_LW, 0, 1);
        checkOutput("lw_wb_state", state, 4);
        checkOutput("lw_wb_res", resultSrc, 1);
        checkOutput("lw_wb_regw", regWrite, 1);
        checkOutput("lw_wb_done", done, 1);
        @(negedge clk);

        // sw with one stall cycle, then a FETCH stall
        advance(I_SW, 0, 2);
        applyStimulus(I_SW, 0, 1);
        checkOutput("sw_ma_imm", immSrc, 1);
        @(negedge clk);
        applyStimulus(I_SW, 0, 0);
        checkOutput("sw_mw_state0", state, 5);
        checkOutput("sw_mw_wr0", memWrite, 1);
        checkOutput("sw_mw_adr0", adrSrc, 1);
        checkOutput("sw_mw_done0", done, 0);
        @(negedge clk);
        applyStimulus(I_SW, 0, 1);
        checkOutput("sw_mw_state1", state, 5);
        checkOutput("sw_mw_wr1", memWrite, 1);
        checkOutput("sw_mw_adr1", adrSrc, 1);
        checkOutput("sw_mw_done1", done, 1);
        @(negedge clk);
        applyStimulus(I_SW, 0, 0);
        checkOutput("fstall_state0", state, 0);
        checkOutput("fstall_wr", memWrite, 0);
        checkOutput("fstall_irw", irWrite, 0);
        checkOutput("fstall_pcw", pcWrite, 0);
        @(negedge clk);
        applyStimulus(I_SW, 0, 0);
        checkOutput("fstall_state1", state, 0);
        @(negedge clk);

        // beq taken and not taken
        advance(I_BEQ, 1, 2);
        applyStimulus(I_BEQ, 1, 1);
        checkOutput("beq_t_state", state, 10);
        checkOutput("beq_t_pcw", pcWrite, 1);
        checkOutput("beq_t_alu", aluControl, 1);
        checkOutput("beq_t_done", done, 1);
        @(negedge clk);
        advance(I_BEQ, 0, 2);
        applyStimulus(I_BEQ, 0, 1);
        checkOutput("beq_n_state", state, 10);
        checkOutput("beq_n_pcw", pcWrite, 0);
        @(negedge clk);

        // jal
        advance(I_JAL, 0, 2);
        applyStimulus(I_JAL, 0, 1);
        checkOutput("jal_state", state, 9);
        checkOutput("jal_pcw", pcWrite, 1);
        checkOutput("jal_srca", aluSrcA, 1);
        checkOutput("jal_srcb", aluSrcB, 2);
        advance(I_JAL, 0, 2);

        // illegal opcode
        advance(I_ILL, 0, 1);
        applyStimulus(I_ILL, 0, 1);
        checkOutput("ill_state", state, 1);
        checkOutput("ill_flag", illegal, 1);
        checkOutput("ill_done", done, 1);
        @(negedge clk);
        applyStimulus(I_ILL, 0, 0);
        checkOutput("ill_after_state", state, 0);
        checkOutput("ill_after_flag", illegal, 0);
        @(negedge clk);

        measureCycles("cpi_sw", I_SW, 0, 4);
        measureCycles("cpi_r", I_ADD, 0, 4);
        measureCycles("cpi_i", I_ADDI, 0, 4);
        measureCycles("cpi_jal", I_JAL, 0, 4);
        measureCycles("cpi_beq", I_BEQ, 1, 3);
        measureCycles("cpi_ill", I_ILL, 0, 2);
        measureCycles("cpi_lw", I_LW, 0, 5);

        // asynchronous reset while stalled in MEMREAD
        advance(I_LW, 0, 3);
        applyStimulus(I_LW, 0, 0);
        checkOutput("arst_pre_state", state, 3);
        rst      = 1'b1;
        memReady = 1'b1;
        #1;
        checkOutput("arst_state", state, 0);
        checkOutput("arst_irw", irWrite, 0);
        checkOutput("arst_pcw", pcWrite, 0);
        checkOutput("arst_regw", regWrite, 0);
        checkOutput("arst_memw", memWrite, 0);
        checkOutput("arst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        measureCycles("cpi_post_rst", I_ADD, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
